// File: rtl/parking_sensor_conditioner_pkg.sv
// Shared constants for the parking-lot gate sensor front end.
package parking_pkg;

    // Cycles a new synchronized level must hold before the clean output follows it.
    localparam int DEBOUNCE_CYCLES_DEFAULT = 4;

    // Cycles a clean level may stay high before the stuck-sensor flag is raised.
    localparam int STUCK_CYCLES_DEFAULT = 1_000_000;

    // Width of the saturating stuck-sensor counter.
    localparam int STUCK_CNT_W = 24;

endpackage

// File: rtl/parking_sensor_conditioner_if.sv
// Bundles the raw sensor levels and the conditioned outputs of both gate sensors.
interface parking_sensor_conditioner_if;

    logic a_raw;
    logic b_raw;
    logic a_clean;
    logic b_clean;
    logic a_fault;
    logic b_fault;

    // Sensor side: drives the raw switch levels and observes the conditioned results.
    modport master (
        output a_raw,
        output b_raw,
        input  a_clean,
        input  b_clean,
        input  a_fault,
        input  b_fault
    );

    // Conditioner side.
    modport slave (
        input  a_raw,
        input  b_raw,
        output a_clean,
        output b_clean,
        output a_fault,
        output b_fault
    );

endinterface

// File: rtl/parking_sensor_conditioner_channel.sv
// One gate sensor: two-flop synchronizer, debounce filter and stuck-high detector.
module sensor_channel
    import parking_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int STUCK_CYCLES    = STUCK_CYCLES_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic clean,
    output logic fault
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [STUCK_CNT_W-1:0] SCNT_LAST = STUCK_CNT_W'(STUCK_CYCLES - 1);

    logic                   s1;
    logic                   s2;
    logic [DW-1:0]          dcnt;
    logic [STUCK_CNT_W-1:0] scnt;

    // Bring the asynchronous switch level into the clock domain; only s2 is used.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // Adopt a new level only after it differs from clean for DEBOUNCE_CYCLES
    // consecutive cycles; any return to the clean level restarts the count.
    always_ff @(posedge clock) begin
        if (reset) begin
            dcnt  <= '0;
            clean <= 1'b0;
        end else if (s2 == clean) begin
            dcnt <= '0;
        end else if (dcnt == DCNT_LAST) begin
            clean <= s2;
            dcnt  <= '0;
        end else begin
            dcnt <= dcnt + DW'(1);
        end
    end

    // Count how long clean has been high; saturate and flag once the limit is hit.
    // The flag is purely informational and never touches clean.
    always_ff @(posedge clock) begin
        if (reset) begin
            scnt  <= '0;
            fault <= 1'b0;
        end else if (!clean) begin
            scnt  <= '0;
            fault <= 1'b0;
        end else if (scnt == SCNT_LAST) begin
            fault <= 1'b1;
        end else begin
            scnt <= scnt + STUCK_CNT_W'(1);
        end
    end

endmodule

// File: rtl/parking_sensor_conditioner.sv
// Conditions the two gate sensors feeding the parking-lot entry/exit FSM.
// Channels are independent; this level only wires two channel instances.
module parking_sensor_conditioner
    import parking_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int STUCK_CYCLES    = STUCK_CYCLES_DEFAULT
) (
    input  logic                          clock,
    input  logic                          reset,
    parking_sensor_conditioner_if.slave   sens
);

    sensor_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .STUCK_CYCLES    (STUCK_CYCLES)
    ) u_chan_a (
        .clock (clock),
        .reset (reset),
        .raw   (sens.a_raw),
        .clean (sens.a_clean),
        .fault (sens.a_fault)
    );

    sensor_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .STUCK_CYCLES    (STUCK_CYCLES)
    ) u_chan_b (
        .clock (clock),
        .reset (reset),
        .raw   (sens.b_raw),
        .clean (sens.b_clean),
        .fault (sens.b_fault)
    );

endmodule

// File: tb/tb_parking_sensor_conditioner.sv
// Scoreboard bench: stimulus pushes expected outputs from a history-window model,
// a monitor pops and compares after every clock edge.
module tb_parking_sensor_conditioner;

    localparam int DEB   = 4;
    localparam int STUCK = 16;
    localparam int HL    = 64;

    logic clock = 1'b0;
    logic reset;

    parking_sensor_conditioner_if sens_if ();

    parking_sensor_conditioner #(
        .DEBOUNCE_CYCLES (DEB),
        .STUCK_CYCLES    (STUCK)
    ) dut (
        .clock (clock),
        .reset (reset),
        .sens  (sens_if)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;
    int edge_no  = 0;

    logic [3:0] expq [$];

    // Model history: raw_h[ch][0] is the raw level sampled at the newest edge,
    // clean_h[ch][0] the clean level after the newest edge.
    bit raw_h   [2][HL];
    bit clean_h [2][HL];

    // Clean flips when the synchronized level (raw two edges back) disagreed
    // with it on each of the last DEB edges; fault is set when clean stayed high
    // after each of the previous STUCK edges.
    task automatic model_edge(input int ch, input bit raw, input bit rst,
                              output bit cl, output bit fl);
        bit prev;
        bit flip;
        if (rst) begin
            for (int i = 0; i < HL; i++) begin
                raw_h[ch][i]   = 1'b0;
                clean_h[ch][i] = 1'b0;
            end
            cl = 1'b0;
            fl = 1'b0;
        end else begin
            for (int i = HL - 1; i > 0; i--) raw_h[ch][i] = raw_h[ch][i-1];
            raw_h[ch][0] = raw;
            prev = clean_h[ch][0];
            flip = 1'b1;
            for (int i = 2; i < DEB + 2; i++)
                if (raw_h[ch][i] == prev) flip = 1'b0;
            cl = flip ? !prev : prev;
            fl = 1'b1;
            for (int i = 0; i < STUCK; i++)
                if (!clean_h[ch][i]) fl = 1'b0;
            for (int i = HL - 1; i > 0; i--) clean_h[ch][i] = clean_h[ch][i-1];
            clean_h[ch][0] = cl;
        end
    endtask

    // One clock of stimulus: drive on the falling edge, predict the next rising edge.
    task automatic cyc(input bit a, input bit b, input bit r);
        bit ca, fa, cb, fb;
        @(negedge clock);
        sens_if.a_raw = a;
        sens_if.b_raw = b;
        reset         = r;
        model_edge(0, a, r, ca, fa);
        model_edge(1, b, r, cb, fb);
        expq.push_back({ca, cb, fa, fb});
    endtask

    task automatic run(input bit a, input bit b, input int n);
        for (int i = 0; i < n; i++) cyc(a, b, 1'b0);
    endtask

    task automatic rst_pulse(input bit a, input bit b, input int n);
        for (int i = 0; i < n; i++) cyc(a, b, 1'b1);
    endtask

    // Monitor: every rising edge presents a new output word to compare.
    initial begin
        logic [3:0] exp_v;
        logic [3:0] act_v;
        forever begin
            @(posedge clock);
            #1;
            edge_no++;
            if (expq.size() > 0) begin
                exp_v = expq.pop_front();
                act_v = {sens_if.a_clean, sens_if.b_clean, sens_if.a_fault, sens_if.b_fault};
                checks++;
                if (act_v !== exp_v)
                begin
                    failures++;
                    $display("FAIL outputs edge=%0d {a_clean,b_clean,a_fault,b_fault} actual=%b expected=%b",
                             edge_no, act_v, exp_v);
                end
            end
        end
    end

    // Random per-channel level generator: mostly holds long enough to qualify
    // (and sometimes to trip the stuck flag), occasionally short glitches.
    bit lvl [2];
    int rem [2];

    initial begin
        sens_if.a_raw = 1'b0;
        sens_if.b_raw = 1'b0;
        reset         = 1'b1;

        // Reset then idle.
        rst_pulse(0, 0, 2);
        run(0, 0, 20);

        // Clean rise on A, held into a stuck fault, then released.
        run(1, 0, 30);
        run(0, 0, 12);

        // Bounce on B: never qualifies.
        run(0, 1, 3); run(0, 0, 1); run(0, 1, 3); run(0, 0, 10);
        // Same bounce with the final high held long enough.
        run(0, 1, 3); run(0, 0, 1); run(0, 1, 8); run(0, 0, 12);

        // Car entry sequence, both channels in parallel.
        run(1, 0, 10); run(1, 1, 10); run(0, 1, 10); run(0, 0, 10);
        // Simultaneous switch on both channels.
        run(1, 1, 12); run(0, 0, 12);

        // Reset mid-debounce and mid-stuck-count with A held high.
        run(1, 0, 4);
        rst_pulse(1, 0, 1);
        run(1, 0, 15);
        rst_pulse(1, 0, 1);
        run(1, 0, 30);
        run(0, 0, 10);

        // Randomized traffic with occasional resets.
        for (int ch = 0; ch < 2; ch++) begin
            lvl[ch] = 1'b0;
            rem[ch] = 1;
        end
        for (int n = 0; n < 3000; n++) begin
            for (int ch = 0; ch < 2; ch++) begin
                rem[ch]--;
                if (rem[ch] <= 0) begin
                    lvl[ch] = !lvl[ch];
                    rem[ch] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, DEB - 1))
                                                          : int'($urandom_range(DEB, 28));
                end
            end
            cyc(lvl[0], lvl[1], ($urandom_range(0, 249) == 0));
        end
        run(0, 0, 10);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 5 && expq.size() > 0; i++) @(posedge clock);
        #2;
        checks++;
        if (expq.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", expq.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/parking_sensor_conditioner.md
Name: parking_sensor_conditioner

Overview:
- Front-end stage directly upstream of the parking-lot entry/exit FSM.
- Takes the raw, asynchronous, bouncy gate-sensor switches A and B and delivers clean, synchronous, debounced levels on a_clean/b_clean, which drive the FSM's a/b inputs.
- Per-channel stuck-sensor detection flags a sensor held active abnormally long (blocked beam, failed switch).
- Purely a conditioning stage: no counting of cars, no display.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive synchronized cycles a new level must hold before a_clean/b_clean adopts it; legal range 1..255.
- STUCK_CYCLES, 1_000_000, consecutive cycles a clean level may stay 1 before the channel's fault flag asserts; legal range 2..2^24-1.

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- a_raw  input  1  raw sensor A, asynchronous to clock, 1 = car present
- b_raw  input  1  raw sensor B, asynchronous to clock, 1 = car present
- a_clean  output  1  debounced, synchronized A level to the FSM
- b_clean  output  1  debounced, synchronized B level to the FSM
- a_fault  output  1  A held active >= STUCK_CYCLES
- b_fault  output  1  B held active >= STUCK_CYCLES

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clock. All state updates on posedge clock only.
- Reset values: a_clean = b_clean = 0, a_fault = b_fault = 0, both synchronizer flops 0, debounce counters 0, stuck counters 0.
- Channels A and B are fully independent. There is no cross-channel interaction; simultaneous transitions on both channels are handled in parallel.
- Synchronizer: two-flop chain per channel, s1 <= raw, s2 <= s1. Only s2 is used downstream.
- Debounce, per channel, with counter dcnt of width $clog2(DEBOUNCE_CYCLES+1):
  - If s2 == clean: dcnt <= 0.
  - If s2 != clean and dcnt == DEBOUNCE_CYCLES-1: clean <= s2 and dcnt <= 0.
  - Otherwise: dcnt <= dcnt + 1.
- Latency: a raw level stable from before posedge k appears on clean after posedge k+1+DEBOUNCE_CYCLES. That is 2+DEBOUNCE_CYCLES edges; 6 with the default.
- Glitch rejection: any s2 excursion shorter than DEBOUNCE_CYCLES cycles is ignored entirely. A single-cycle return to the clean level restarts the count from 0.
- DEBOUNCE_CYCLES = 1 degenerates to a pure 2-flop synchronizer plus one register stage.
- Stuck detection, per channel, with saturating counter scnt of width 24:
  - clean == 0: scnt <= 0 and fault <= 0. Fault clears on the cycle after clean falls.
  - clean == 1 and scnt < STUCK_CYCLES-1: scnt <= scnt + 1.
  - clean == 1 and scnt == STUCK_CYCLES-1: fault <= 1 and scnt holds (saturates, no wrap).
  - Fault therefore rises STUCK_CYCLES edges after clean rose.
- The fault flag is informational only. It never forces or masks a_clean/b_clean.
- Reset asserted mid-debounce or mid-stuck-count: all counters and outputs return to reset values on that edge.
  - After release, a raw input that is still high re-qualifies with the full 2+DEBOUNCE_CYCLES latency. No stale state survives.
- All outputs are registered. There is no combinational path from raw inputs to outputs.

Decomposition:
- Package parking_pkg:
  - Default constants DEBOUNCE_CYCLES_DEFAULT and STUCK_CYCLES_DEFAULT.
  - STUCK_CNT_W = 24.
- One sub-module, sensor_channel: synchronizer + debounce + stuck counter for a single sensor.
  - Parameterized by DEBOUNCE_CYCLES and STUCK_CYCLES.
  - Ports: clock, reset, raw, clean, fault.
  - The top instantiates it twice (A, B) and holds no other logic.

Test Plan (bench overrides DEBOUNCE_CYCLES=4, STUCK_CYCLES=16):
- Reset then idle: reset high 2 cycles, raw inputs 0 for 20 cycles -> a_clean, b_clean, a_fault, b_fault all 0 throughout.
- Clean rise: a_raw 0->1 before posedge k, held -> a_clean 0 through posedge k+4, 1 after posedge k+5. b_clean stays 0.
- Bounce rejection: b_raw pulses 1 for 3 cycles, 0 for 1, 1 for 3, then 0 -> b_clean never rises. Same pattern with the final 1 held 4+ cycles -> b_clean rises 6 edges after that stable 1 began.
- Stuck fault: a_raw held 1 -> a_clean rises at edge 6, a_fault rises 16 edges later and stays 1. a_raw released -> a_clean falls after 6 edges, a_fault 0 one edge later.
- Simultaneous channels: full car-entry sequence a=1; a=1,b=1; a=0,b=1; a=0,b=0, each phase held 10 cycles -> clean outputs reproduce the sequence, each edge delayed exactly 6 cycles. Both channels switch on the same edge where the raw inputs do.
- Reset mid-operation: a_raw=1, reset pulsed at debounce count 2 and again at stuck count 10 -> outputs 0 on the reset edge. a_clean re-rises 6 edges after release; a_fault needs a fresh 16 cycles.
